// File: rtl/shreg_pkg.sv
// Shared definitions for the radix-2^DIGIT shift register slice.
//   S_IDLE/S_RUN/S_DONE : FSM state encoding
//   cnt_width()         : width of a counter that must hold 0..steps
package shreg_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic int cnt_width(input int steps);
    return (steps < 1) ? 1 : $clog2(steps + 1);
  endfunction

endpackage

// File: rtl/shift_step_counter.sv
// Saturating step counter for the shift sequence.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr       : restart count at 0 (operand load)
//   inc       : count one accepted shift
//   set_max   : jump straight to STEPS (early finish)
//   cnt       : shifts done since the last clear
//   tc        : terminal count, cnt == STEPS
//   last      : cnt == STEPS-1, the next shift finishes the sequence
import shreg_pkg::*;

module shift_step_counter #(
  parameter int STEPS = 514,
  parameter int CW    = cnt_width(STEPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic          set_max,
  output logic [CW-1:0] cnt,
  output logic          tc,
  output logic          last
);

  localparam int            LAST_I = STEPS - 1;
  localparam logic [CW-1:0] MAX    = STEPS[CW-1:0];
  localparam logic [CW-1:0] LAST   = LAST_I[CW-1:0];

  always_ff @(posedge clk) begin
    if (rst || clr)                cnt <= '0;
    else if (set_max)              cnt <= MAX;
    else if (inc && (cnt != MAX))  cnt <= cnt + 1'b1;
  end

  assign tc   = (cnt == MAX);
  assign last = (cnt == LAST);

endmodule

// File: rtl/shift_register_radix.sv
// Right-shift register feeding a radix-2^DIGIT Montgomery loop.
// Loads an operand, then shifts it right by DIGIT bits per accepted request.
// Optional feature macro: SHREG_EARLY_ZERO_EN (adds zero_flag and early finish
// once the register has drained to zero).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture in_number and restart (wins over shift)
//   in_number  : operand
//   shift      : request one DIGIT-bit logical right shift (RUN only)
//   out_shift  : registered current value
//   digit_out  : low DIGIT bits of out_shift
//   step_cnt   : shifts done since the last load
//   shift_done : one-cycle pulse after each accepted shift
//   all_done   : level, step_cnt == STEPS
//   busy       : high in RUN
//   zero_flag  : (SHREG_EARLY_ZERO_EN only) out_shift == 0, registered
import shreg_pkg::*;

module shift_register_radix #(
  parameter int WIDTH = 1028,
  parameter int DIGIT = 2,
  parameter int STEPS = 514
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [WIDTH-1:0]              in_number,
  input  logic                          shift,
  output logic [WIDTH-1:0]              out_shift,
  output logic [DIGIT-1:0]              digit_out,
  output logic [cnt_width(STEPS)-1:0]   step_cnt,
  output logic                          shift_done,
  output logic                          all_done,
`ifdef SHREG_EARLY_ZERO_EN
  output logic                          zero_flag,
`endif
  output logic                          busy
);

  localparam int CW = cnt_width(STEPS);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_shreg;
  logic             r_shift_done;
  logic             r_busy;

  logic [WIDTH-1:0] w_shifted;
  logic             w_do_shift;
  logic             w_finish;
  logic             w_set_max;
  logic             w_tc;
  logic             w_last;
  logic [CW-1:0]    w_cnt;

  // Always shift the live register so consecutive shifts compound.
  assign w_shifted  = {{DIGIT{1'b0}}, r_shreg[WIDTH-1:DIGIT]};
  // Load has priority; a shift arriving with it is dropped.
  assign w_do_shift = (r_state == S_RUN) && shift && !load;

`ifdef SHREG_EARLY_ZERO_EN
  logic r_zero;

  // Tracks whether the register value about to be held is zero.
  always_ff @(posedge clk) begin
    if (rst)             r_zero <= 1'b1;
    else if (load)       r_zero <= (in_number == '0);
    else if (w_do_shift) r_zero <= (w_shifted == '0);
  end

  assign zero_flag = r_zero;
  assign w_set_max = w_do_shift && r_zero;
  assign w_finish  = w_last || r_zero;
`else
  assign w_set_max = 1'b0;
  assign w_finish  = w_last;
`endif

  shift_step_counter #(
    .STEPS (STEPS),
    .CW    (CW)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (load),
    .inc     (w_do_shift),
    .set_max (w_set_max),
    .cnt     (w_cnt),
    .tc      (w_tc),
    .last    (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_shreg      <= '0;
      r_shift_done <= 1'b0;
      r_busy       <= 1'b0;
    end else if (load) begin
      r_state      <= S_RUN;
      r_shreg      <= in_number;
      r_shift_done <= 1'b0;
      r_busy       <= 1'b1;
    end else if (w_do_shift) begin
      r_shreg      <= w_shifted;
      r_shift_done <= 1'b1;
      if (w_finish) begin
        r_state <= S_DONE;
        r_busy  <= 1'b0;
      end
    end else begin
      r_shift_done <= 1'b0;
    end
  end

  assign out_shift  = r_shreg;
  assign digit_out  = r_shreg[DIGIT-1:0];
  assign step_cnt   = w_cnt;
  assign shift_done = r_shift_done;
  assign all_done   = w_tc;
  assign busy       = r_busy;

endmodule

// File: tb/tb_shift_register_radix.sv
module tb_shift_register_radix;

  localparam int WIDTH = 8;
  localparam int DIGIT = 2;
  localparam int STEPS = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] in_number = '0;
  logic             shift = 1'b0;
  logic [WIDTH-1:0] out_shift;
  logic [DIGIT-1:0] digit_out;
  logic [2:0]       step_cnt;
  logic             shift_done;
  logic             all_done;
  logic             busy;
`ifdef SHREG_EARLY_ZERO_EN
  logic             zero_flag;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: value is always the loaded operand shifted by
  // DIGIT * (shifts taken) bits; the sequence runs while m_run is set.
  int m_loaded = 0;
  int m_cnt    = 0;
  bit m_run    = 0;
  bit m_pulse  = 0;

  shift_register_radix #(.WIDTH(WIDTH), .DIGIT(DIGIT), .STEPS(STEPS)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .in_number  (in_number),
    .shift      (shift),
    .out_shift  (out_shift),
    .digit_out  (digit_out),
    .step_cnt   (step_cnt),
    .shift_done (shift_done),
    .all_done   (all_done),
`ifdef SHREG_EARLY_ZERO_EN
    .zero_flag  (zero_flag),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic int m_value();
    return (m_loaded >> (DIGIT * m_cnt)) & ((1 << WIDTH) - 1);
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int v;
    v = m_value();
    chk({tag, ".out_shift"},  int'(out_shift),  v);
    chk({tag, ".digit_out"},  int'(digit_out),  v % (1 << DIGIT));
    chk({tag, ".step_cnt"},   int'(step_cnt),   m_cnt);
    chk({tag, ".shift_done"}, int'(shift_done), int'(m_pulse));
    chk({tag, ".all_done"},   int'(all_done),   int'(m_cnt == STEPS));
    chk({tag, ".busy"},       int'(busy),       int'(m_run));
`ifdef SHREG_EARLY_ZERO_EN
    chk({tag, ".zero_flag"},  int'(zero_flag),  int'(v == 0));
`endif
  endtask

  // One clock with the given inputs, then advance the model and compare.
  task automatic step(input string tag, input bit r, input bit l,
                      input logic [WIDTH-1:0] d, input bit s);
    bit zero_now;
    rst = r; load = l; in_number = d; shift = s;
    zero_now = (m_value() == 0);
    @(posedge clk);
    #1;
    if (r) begin
      m_loaded = 0; m_cnt = 0; m_run = 0; m_pulse = 0;
    end else if (l) begin
      m_loaded = int'(d); m_cnt = 0; m_run = 1; m_pulse = 0;
    end else if (m_run && s) begin
      m_cnt++;
      m_pulse = 1;
`ifdef SHREG_EARLY_ZERO_EN
      if (zero_now) m_cnt = STEPS;
`endif
      if (m_cnt == STEPS) m_run = 0;
    end else begin
      m_pulse = 0;
    end
    if (zero_now) begin end
    check_all(tag);
  endtask

  initial begin
    bit r, l, s;
    logic [WIDTH-1:0] d;

    // Reset state
    step("reset0", 1, 0, 8'h00, 0);
    step("reset1", 1, 1, 8'hAA, 1);

    // Shift in IDLE is ignored
    step("idle_sh0", 0, 0, 8'h00, 1);
    step("idle_sh1", 0, 0, 8'h00, 1);

    // Load B4, four shifts
    step("ldB4", 0, 1, 8'hB4, 0);
    chk("ldB4.busy_const", int'(busy), 1);
    step("b4_s1", 0, 0, 8'h00, 1);
    chk("b4_s1.const", int'(out_shift), 'h2D);
    chk("b4_s1.dig", int'(digit_out), 1);
    step("b4_s2", 0, 0, 8'h00, 1);
    chk("b4_s2.const", int'(out_shift), 'h0B);
    step("b4_s3", 0, 0, 8'h00, 1);
    chk("b4_s3.const", int'(out_shift), 'h02);
    chk("b4_s3.dig", int'(digit_out), 2);
    step("b4_s4", 0, 0, 8'h00, 1);
    chk("b4_s4.const", int'(out_shift), 'h00);
    chk("b4_s4.all_done", int'(all_done), 1);

    // DONE: shift held 3 cycles, then reload
    step("done_sh0", 0, 0, 8'h00, 1);
    step("done_sh1", 0, 0, 8'h00, 1);
    step("done_sh2", 0, 0, 8'h00, 1);
    chk("done.cnt_const", int'(step_cnt), 4);
    step("ld0C", 0, 1, 8'h0C, 0);

    // Load with simultaneous shift: shift dropped
    step("ldFF_sh", 0, 1, 8'hFF, 1);
    chk("ldFF.const", int'(out_shift), 'hFF);
    step("ff_s1", 0, 0, 8'h00, 1);
    chk("ff_s1.const", int'(out_shift), 'h3F);

    // Reset mid-run
    step("ldB4b", 0, 1, 8'hB4, 0);
    step("b4b_s1", 0, 0, 8'h00, 1);
    step("b4b_s2", 0, 0, 8'h00, 1);
    step("midrst", 1, 0, 8'h00, 1);
    step("post_rst0", 0, 0, 8'h00, 1);
    step("post_rst1", 0, 0, 8'h00, 1);

    // Idle gap then shift pause in RUN
    step("ld5A", 0, 1, 8'h5A, 0);
    step("5a_gap", 0, 0, 8'h00, 0);
    step("5a_s1", 0, 0, 8'h00, 1);
    step("5a_gap2", 0, 0, 8'h00, 0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 39) == 0);
      l = ($urandom_range(0, 7) == 0);
      s = ($urandom_range(0, 3) != 0);
      d = WIDTH'($urandom);
      step("rand", r, l, d, s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
